serial_frame_deserializer: RTL and testbench

Downstream consumer of the serial shift-register stage. It takes the 1-bit-per-clock stream that stage emits, hunts for a sync pattern, and deserializes the following WIDTH data bits into a parallel word. The word is presented on a valid/ready output port backed by a one-entry holding buffer, which feeds the parallel-side logic of the design.

---
 rtl/serial_frame_pkg.sv | 19 +
 rtl/serial_sync_detector.sv | 45 ++++
 rtl/serial_frame_deserializer.sv | 180 ++++++++++++++++++
 tb/tb_serial_frame_deserializer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_frame_pkg.sv
// Shared types and constants for the serial frame deserializer.
// Optional parity support is selected by the SERIAL_FRAME_PARITY_EN macro.
package serial_frame_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    COLLECT = 2'd1,
    PARITY  = 2'd2
  } state_t;

  localparam int DEFAULT_SYNC_WIDTH = 4;
  localparam logic [3:0] DEFAULT_SYNC = 4'b1011;

  // Bit counter must be able to hold 0..width.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_sync_detector.sv
// Sync-pattern hunter: keeps the recent-bit window and a saturating fill count.
// Match is combinational on the last sync bit so the next bit is the first data bit.
module serial_sync_detector
  import serial_frame_pkg::*;
#(
  parameter int SYNC_WIDTH = DEFAULT_SYNC_WIDTH,
  parameter logic [SYNC_WIDTH-1:0] SYNC = DEFAULT_SYNC
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  input  logic clear,
  output logic match
);

  localparam int FILL_W = $clog2(SYNC_WIDTH);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(SYNC_WIDTH - 1);

  // Only the oldest SYNC_WIDTH-1 bits need storing; the newest bit is `in`.
  logic [SYNC_WIDTH-2:0] window_r;
  logic [FILL_W-1:0]     fill_r;
  logic [SYNC_WIDTH-1:0] candidate_s;

  assign candidate_s = {window_r, in};
  assign match       = (fill_r == FILL_MAX) && (candidate_s == SYNC);

  // Window shift and saturating fill count, cleared whenever hunting restarts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      window_r <= '0;
      fill_r   <= '0;
    end else if (clear) begin
      window_r <= '0;
      fill_r   <= '0;
    end else begin
      window_r <= candidate_s[SYNC_WIDTH-2:0];
      if (fill_r != FILL_MAX) begin
        fill_r <= fill_r + FILL_W'(1);
      end else begin
        fill_r <= fill_r;
      end
    end
  end

endmodule

// File: rtl/serial_frame_deserializer.sv
// Serial-to-parallel frame deserializer with a one-entry valid/ready output buffer.
// Define SERIAL_FRAME_PARITY_EN to expect an even-parity bit after each data word.
module serial_frame_deserializer
  import serial_frame_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SYNC_WIDTH = DEFAULT_SYNC_WIDTH,
  parameter logic [SYNC_WIDTH-1:0] SYNC = DEFAULT_SYNC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow,
  output logic             parity_err
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state_r;
  state_t           next_state_s;
  logic [CNT_W-1:0] bit_cnt_r;
  logic [WIDTH-1:0] shreg_r;
  logic             match_s;
  logic             clear_s;
  logic             last_bit_s;
  logic             complete_s;
  logic [WIDTH-1:0] done_word_s;
  logic             load_ok_s;

`ifdef SERIAL_FRAME_PARITY_EN
  logic parity_bad_s;

  function automatic logic even_parity(input logic [WIDTH-1:0] word);
    return ^word;
  endfunction
`endif

  // Hold the detector cleared outside HUNT so each frame needs a fresh sync.
  assign clear_s    = (state_r != HUNT) || match_s;
  assign last_bit_s = (bit_cnt_r == LAST_BIT);
  assign load_ok_s  = !out_valid || out_ready;

  serial_sync_detector #(
    .SYNC_WIDTH(SYNC_WIDTH),
    .SYNC      (SYNC)
  ) u_sync (
    .clk  (clk),
    .rst  (rst),
    .in   (in),
    .clear(clear_s),
    .match(match_s)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= HUNT;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      HUNT: begin
        if (match_s) begin
          next_state_s = COLLECT;
        end else begin
          next_state_s = HUNT;
        end
      end
      COLLECT: begin
        if (last_bit_s) begin
`ifdef SERIAL_FRAME_PARITY_EN
          next_state_s = PARITY;
`else
          next_state_s = HUNT;
`endif
        end else begin
          next_state_s = COLLECT;
        end
      end
      PARITY:  next_state_s = HUNT;
      default: next_state_s = HUNT;
    endcase
  end

  // FSM outputs: word completion strobe and the word being completed.
  always_comb begin
    complete_s  = 1'b0;
    done_word_s = shreg_r;
`ifdef SERIAL_FRAME_PARITY_EN
    parity_bad_s = 1'b0;
`endif
    case (state_r)
      COLLECT: begin
`ifdef SERIAL_FRAME_PARITY_EN
        complete_s = 1'b0;
`else
        if (last_bit_s) begin
          complete_s  = 1'b1;
          done_word_s = {shreg_r[WIDTH-2:0], in};
        end else begin
          complete_s = 1'b0;
        end
`endif
      end
      PARITY: begin
`ifdef SERIAL_FRAME_PARITY_EN
        complete_s   = 1'b1;
        done_word_s  = shreg_r;
        parity_bad_s = (in != even_parity(shreg_r));
`else
        complete_s = 1'b0;
`endif
      end
      default: complete_s = 1'b0;
    endcase
  end

  // Data shift register and bit counter; the word is held through PARITY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_r   <= '0;
      bit_cnt_r <= '0;
    end else if (state_r == COLLECT) begin
      shreg_r <= {shreg_r[WIDTH-2:0], in};
      if (last_bit_s) begin
        bit_cnt_r <= '0;
      end else begin
        bit_cnt_r <= bit_cnt_r + CNT_W'(1);
      end
    end else begin
      shreg_r   <= shreg_r;
      bit_cnt_r <= '0;
    end
  end

  // Holding buffer: load when empty or draining, otherwise drop and flag overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out  <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else if (complete_s) begin
      if (load_ok_s) begin
        data_out  <= done_word_s;
        out_valid <= 1'b1;
      end else begin
        overflow  <= 1'b1;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

`ifdef SERIAL_FRAME_PARITY_EN
  // Sticky parity error; the word itself is still delivered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_err <= 1'b0;
    end else if (complete_s && parity_bad_s) begin
      parity_err <= 1'b1;
    end else begin
      parity_err <= parity_err;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_frame_deserializer.sv
// Self-checking bench for serial_frame_deserializer: directed scenarios plus
// random framed traffic, compared cycle by cycle against a queue-based model.
module tb_serial_frame_deserializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in;
  logic       out_ready;
  logic [7:0] data_out;
  logic       out_valid;
  logic       overflow;
  logic       parity_err;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit         hunt_q[$];
  int         m_mode;
  int         m_cnt;
  logic [7:0] m_acc;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ovf;
  logic       m_perr;
  int         xfers;
  logic [7:0] last_xfer;
  logic       rand_rdy = 1'b0;

  serial_frame_deserializer #(
    .WIDTH     (8),
    .SYNC_WIDTH(4),
    .SYNC      (4'b1011)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in),
    .data_out  (data_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow),
    .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hunt_q.delete();
    m_mode  = 0;
    m_cnt   = 0;
    m_acc   = 8'h00;
    m_valid = 1'b0;
    m_data  = 8'h00;
    m_ovf   = 1'b0;
    m_perr  = 1'b0;
  endtask

  // Apply one sampled bit and the consumer's ready to the frame rules.
  task automatic model_edge(input logic b, input logic rdy);
    logic       done;
    logic       pbad;
    logic [7:0] w;
    logic [3:0] pat;
    int         n;
    done = 1'b0;
    pbad = 1'b0;
    w    = 8'h00;
    if (m_mode == 0) begin
      hunt_q.push_back(b);
      n = hunt_q.size();
      if (n >= 4) begin
        pat = {hunt_q[n-4], hunt_q[n-3], hunt_q[n-2], hunt_q[n-1]};
        if (pat == 4'b1011) begin
          m_mode = 1;
          m_cnt  = 0;
          hunt_q.delete();
        end
      end
    end else if (m_mode == 1) begin
      m_acc = {m_acc[6:0], b};
      m_cnt++;
      if (m_cnt == 8) begin
`ifdef SERIAL_FRAME_PARITY_EN
        m_mode = 2;
`else
        done   = 1'b1;
        w      = m_acc;
        m_mode = 0;
`endif
      end
    end else begin
      done   = 1'b1;
      w      = m_acc;
      pbad   = (b != ^m_acc);
      m_mode = 0;
    end
    if (done) begin
      if (!m_valid || rdy) begin
        m_data  = w;
        m_valid = 1'b1;
      end else begin
        m_ovf = 1'b1;
      end
      if (pbad) m_perr = 1'b1;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
  endtask

  // Drive one bit for one clock, then compare all outputs with the model.
  task automatic step(input logic b, input logic rdy);
    logic r;
    r = rand_rdy ? ($urandom_range(0, 3) != 0) : rdy;
    in        = b;
    out_ready = r;
    if (out_valid && r) begin
      xfers++;
      last_xfer = data_out;
    end
    model_edge(b, r);
    @(posedge clk);
    #1;
    check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    if (m_valid) check("data_out", {24'd0, data_out}, {24'd0, m_data});
    check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    check("parity_err", {31'd0, parity_err}, {31'd0, m_perr});
  endtask

  // Sync + data (+ parity); last_rdy applies to the final bit of the frame.
  task automatic send_frame(input logic [7:0] d, input logic rdy, input logic last_rdy,
                            input logic par_flip);
    logic [3:0] sync_v;
    sync_v = 4'b1011;
    for (int i = 3; i >= 0; i--) step(sync_v[i], rdy);
`ifdef SERIAL_FRAME_PARITY_EN
    for (int i = 7; i >= 0; i--) step(d[i], rdy);
    step((^d) ^ par_flip, last_rdy);
`else
    for (int i = 7; i >= 1; i--) step(d[i], rdy);
    step(d[0], last_rdy);
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_data", {24'd0, data_out}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    check("rst_perr", {31'd0, parity_err}, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in        = 1'b0;
    out_ready = 1'b0;
    xfers     = 0;
    last_xfer = 8'h00;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Basic frame
    xfers = 0;
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
    check("basic_data", {24'd0, data_out}, 32'hA5);
    check("basic_valid", {31'd0, out_valid}, 32'd1);
    step(1'b0, 1'b1);
    check("basic_pulse_end", {31'd0, out_valid}, 32'd0);
    check("basic_xfers", xfers, 32'd1);

    // Backpressure and overflow
    do_reset();
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    check("bp_data", {24'd0, data_out}, 32'hA5);
    check("bp_valid", {31'd0, out_valid}, 32'd1);
    check("bp_ovf", {31'd0, overflow}, 32'd1);
    step(1'b0, 1'b1);
    check("bp_drained", {31'd0, out_valid}, 32'd0);

    // Drain and load on the same edge
    do_reset();
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
    check("sim_data", {24'd0, data_out}, 32'h3C);
    check("sim_valid", {31'd0, out_valid}, 32'd1);
    check("sim_ovf", {31'd0, overflow}, 32'd0);

    // False sync
    do_reset();
    xfers = 0;
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1);
    check("partial_sync_xfers", xfers, 32'd0);
    check("partial_sync_valid", {31'd0, out_valid}, 32'd0);
    step(1'b1, 1'b1); step(1'b0, 1'b1); step(1'b1, 1'b1); step(1'b0, 1'b1);
    step(1'b0, 1'b1); step(1'b1, 1'b1); step(1'b1, 1'b1); step(1'b0, 1'b1);
    send_frame(8'hF0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1);
    check("false_sync_xfers", xfers, 32'd1);
    check("false_sync_word", {24'd0, last_xfer}, 32'hF0);

    // Reset mid-frame, with a buffered word and overflow pending
    do_reset();
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b1, 1'b0);
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    do_reset();
    send_frame(8'h5A, 1'b1, 1'b1, 1'b0);
    check("after_rst_data", {24'd0, data_out}, 32'h5A);
    check("after_rst_valid", {31'd0, out_valid}, 32'd1);

`ifdef SERIAL_FRAME_PARITY_EN
    // Parity good then bad
    do_reset();
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
    check("par_ok", {31'd0, parity_err}, 32'd0);
    send_frame(8'h01, 1'b1, 1'b1, 1'b1);
    check("par_bad_data", {24'd0, data_out}, 32'h01);
    check("par_bad_flag", {31'd0, parity_err}, 32'd1);
`endif

    // Random traffic with noise gaps and random backpressure
    do_reset();
    rand_rdy = 1'b1;
    for (int f = 0; f < 150; f++) begin
      int gap;
      gap = $urandom_range(0, 4);
      for (int g = 0; g < gap; g++) step(1'($urandom_range(0, 1)), 1'b1);
      send_frame(8'($urandom), 1'b1, 1'b1, 1'($urandom_range(0, 7) == 0));
    end
    rand_rdy = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
